// File: rtl/accum_pkg.sv
// Shared types and constants for the sequential accumulator.
//   WIDTH         datapath width; fixed at 16 to match Adder
//   accum_state_t control states IDLE / ACC / DONE
//   word_t        one datapath word
package accum_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } accum_state_t;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/Adder.sv
// 16-bit ripple-carry adder built from four 4-bit ripple slices.
//   adder_4: a, b (4b), cin -> s (4b), cout
//   Adder:   X, Y (16b), cin -> S (16b), cout
module adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module Adder (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);

  logic [4:0] c;

  assign c[0] = cin;

  adder_4 u_a0 (.a(X[3:0]),   .b(Y[3:0]),   .cin(c[0]), .s(S[3:0]),   .cout(c[1]));
  adder_4 u_a1 (.a(X[7:4]),   .b(Y[7:4]),   .cin(c[1]), .s(S[7:4]),   .cout(c[2]));
  adder_4 u_a2 (.a(X[11:8]),  .b(Y[11:8]),  .cin(c[2]), .s(S[11:8]),  .cout(c[3]));
  adder_4 u_a3 (.a(X[15:12]), .b(Y[15:12]), .cin(c[3]), .s(S[15:12]), .cout(c[4]));

  assign cout = c[4];

endmodule

// File: rtl/seq_accumulator.sv
// Sequential multi-operand accumulator in front of the 16-bit Adder.
// Takes len words over in_valid/in_ready, adds or subtracts each into a
// running total, then presents the total plus sticky carry/overflow flags
// over out_valid/out_ready.
//   clk, rst_n         clock, synchronous active-low reset
//   start, len         launch a run of len words (sampled in IDLE only)
//   in_valid/in_ready  input handshake; in_data operand, in_sub 1=subtract
//   out_valid/out_ready result handshake; out_sum, out_carry, out_ovf
//   busy               high while accumulating or holding a result
module seq_accumulator
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  accum_state_t     state, state_next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry, ovf;

  logic [WIDTH-1:0] y, s;
  logic             cout;
  logic             hs;
  logic             step_carry, step_ovf;

  // Subtraction is X + ~Y + 1; the adder's carry-out is then the inverse of
  // the borrow, hence the conditional inversion when folding into carry.
  assign y  = in_data ^ {WIDTH{in_sub}};
  assign hs = in_valid && in_ready;

  Adder u_adder (
    .X    (acc),
    .Y    (y),
    .cin  (in_sub),
    .S    (s),
    .cout (cout)
  );

  assign step_carry = in_sub ? ~cout : cout;
  assign step_ovf   = (acc[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != acc[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (len == '0) ? DONE : ACC;
      ACC:  if (hs && cnt == CNT_W'(1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= len;
            carry <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        ACC: begin
          if (hs) begin
            acc   <= s;
            carry <= carry | step_carry;
            ovf   <= ovf | step_ovf;
            cnt   <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state == ACC) || (state == DONE);
  end

  assign out_sum   = acc;
  assign out_carry = carry;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_seq_accumulator.sv
module tb_seq_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        busy;

  always #5 clk = ~clk;

  seq_accumulator #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  typedef struct {
    string            name;
    logic [7:0]       len;
    logic [3:0][15:0] data;
    logic [3:0]       sub;
    logic [15:0]      sum;
    logic             carry;
    logic             ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a result, compare it with the scoreboard head, then
  // accept it and verify the return to IDLE with the result still visible.
  task automatic collect(input string nm);
    exp_t e;
    int   n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_sum"},   32'(out_sum),   32'(e.sum));
      chk({nm, "_carry"}, 32'(out_carry), 32'(e.carry));
      chk({nm, "_ovf"},   32'(out_ovf),   32'(e.ovf));
      chk({nm, "_in_ready_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_idle_busy"},      32'(busy),      32'd0);
      chk({nm, "_idle_sum_held"},  32'(out_sum),   32'(e.sum));
    end
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1;
    len   = v.len;
    tick();
    start = 1'b0;
    chk({v.name, "_busy"},     32'(busy),     32'd1);
    chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back('{sum: v.sum, carry: v.carry, ovf: v.ovf});
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1;
      in_data  = v.data[i];
      in_sub   = v.sub[i];
      tick();
    end
    in_valid = 1'b0;
    chk({v.name, "_latency"}, 32'(out_valid), 32'd1);
    collect(v.name);
  endtask

  initial begin
    vecs[0] = '{name: "basic",   len: 8'd3, data: {16'h0000, 16'h0003, 16'h0002, 16'h0001},
                sub: 4'b0000, sum: 16'h0006, carry: 1'b0, ovf: 1'b0};
    vecs[1] = '{name: "uwrap",   len: 8'd2, data: {16'h0000, 16'h0000, 16'h0002, 16'hFFFF},
                sub: 4'b0000, sum: 16'h0001, carry: 1'b1, ovf: 1'b0};
    vecs[2] = '{name: "sovf",    len: 8'd2, data: {16'h0000, 16'h0000, 16'h0001, 16'h7FFF},
                sub: 4'b0000, sum: 16'h8000, carry: 1'b0, ovf: 1'b1};
    vecs[3] = '{name: "borrow",  len: 8'd2, data: {16'h0000, 16'h0000, 16'h0007, 16'h0005},
                sub: 4'b0010, sum: 16'hFFFE, carry: 1'b1, ovf: 1'b0};

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(out_sum),   32'd0);
    chk("rst_flags",     32'({out_carry, out_ovf}), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // len=0 straight to DONE; previous run left sum=FFFE and carry=1
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    sb.push_back('{sum: 16'h0000, carry: 1'b0, ovf: 1'b0});
    chk("len0_valid_next", 32'(out_valid), 32'd1);
    collect("len0");

    // Gap in in_valid, then backpressure on the result
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    sb.push_back('{sum: 16'h0030, carry: 1'b0, ovf: 1'b0});
    in_valid = 1'b1; in_data = 16'h0010; in_sub = 1'b0;
    tick();
    in_valid = 1'b0; in_data = 16'hDEAD;
    tick(); tick();
    chk("gap_in_ready",  32'(in_ready),  32'd1);
    chk("gap_no_valid",  32'(out_valid), 32'd0);
    chk("gap_sum",       32'(out_sum),   32'h0010);
    in_valid = 1'b1; in_data = 16'h0020;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_sum_hold",   32'(out_sum),   32'h0030);
      tick();
    end
    collect("backpressure");

    // start coinciding with the DONE->IDLE transition is ignored
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("dstart_done",  32'(out_valid), 32'd1);
    start = 1'b1; len = 8'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("dstart_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("dstart_stays_idle", 32'(busy), 32'd0);
    chk("dstart_sum_held",   32'(out_sum), 32'h1234);

    // Reset in the middle of a run discards the partial result
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0101;
    tick(); tick();
    in_valid = 1'b0;
    chk("mid_partial", 32'(out_sum), 32'h0202);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    chk("mid_rst_sum",       32'(out_sum),   32'd0);
    chk("sb_drained",        32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
